// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//   Master of the single shared memory port. It arbitrates between instruction
//   fetch (IF) and data access (D), with D at fixed higher priority, and runs
//   the full four-phase strobe/ready handshake. The CPU core sees only level
//   requests and one-cycle done pulses.
//
// Optional feature (compile-time macro): MEM_BUS_TIMEOUT_EN
//   Defined   : a wait counter aborts a RD_WAIT/WR_WAIT after TIMEOUT cycles
//               without ready/ack. The abort returns 16'hFFFF for reads and
//               pulses bus_err together with done.
//   Undefined : waits are unbounded and bus_err is tied low.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request (level) and address
//   if_rdata/if_done      fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr     data request (level), write select, address
//   d_wdata               store data
//   d_rdata/d_done        load word and one-cycle completion pulse
//   readM/writeM/address  memory strobes and address
//   data                  bidirectional memory data, driven only in WR_WAIT
//   inputReady/ackOutput  memory read-valid / write-accepted handshakes
//   busy                  high whenever the sequencer is not idle
//   bus_err               abort pulse, coincident with done
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 busy,
  output logic                 bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_RD_REL, S_WR_WAIT, S_WR_REL
  } state_t;

  state_t                 r_state;
  logic                   r_owner_d;   // 1 = current access belongs to D
  logic                   r_readM;
  logic                   r_writeM;
  logic [WORD_SIZE-1:0]   r_addr;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_if_rdata;
  logic [WORD_SIZE-1:0]   r_d_rdata;
  logic                   r_if_done;
  logic                   r_d_done;
  logic                   r_bus_err;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_expired;
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Store data is a pure datapath register: loaded on a write grant, only
  // observed on the bus while in WR_WAIT, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && d_req && d_we)
      r_wdata <= d_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_readM    <= 1'b0;
      r_writeM   <= 1'b0;
      r_addr     <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_bus_err  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      // Completion flags are single-cycle pulses.
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef MEM_BUS_TIMEOUT_EN
          r_cnt <= '0;
`endif
          // D wins ties so an in-flight instruction's data access finishes
          // before the next fetch.
          if (d_req) begin
            r_owner_d <= 1'b1;
            r_addr    <= d_addr;
            if (d_we) begin
              r_writeM <= 1'b1;
              r_state  <= S_WR_WAIT;
            end else begin
              r_readM  <= 1'b1;
              r_state  <= S_RD_WAIT;
            end
          end else if (if_req) begin
            r_owner_d <= 1'b0;
            r_addr    <= if_addr;
            r_readM   <= 1'b1;
            r_state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (inputReady) begin
            if (r_owner_d) begin
              r_d_rdata <= data;
              r_d_done  <= 1'b1;
            end else begin
              r_if_rdata <= data;
              r_if_done  <= 1'b1;
            end
            r_readM <= 1'b0;
            r_state <= S_RD_REL;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (w_expired) begin
            if (r_owner_d) begin
              r_d_rdata <= '1;
              r_d_done  <= 1'b1;
            end else begin
              r_if_rdata <= '1;
              r_if_done  <= 1'b1;
            end
            r_bus_err <= 1'b1;
            r_readM   <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        // Release phases last at least one cycle, so the requester has
        // dropped its level request before IDLE samples again.
        S_RD_REL: begin
          if (!inputReady) r_state <= S_IDLE;
        end
        S_WR_WAIT: begin
          if (ackOutput) begin
            r_writeM <= 1'b0;
            r_d_done <= 1'b1;
            r_state  <= S_WR_REL;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (w_expired) begin
            r_writeM  <= 1'b0;
            r_d_done  <= 1'b1;
            r_bus_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_WR_REL: begin
          if (!ackOutput) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The bus is driven exactly while in WR_WAIT; leaving that state (ack,
  // abort or reset) releases it on the same edge.
  assign data     = (r_state == S_WR_WAIT) ? r_wdata : {WORD_SIZE{1'bz}};

  assign readM    = r_readM;
  assign writeM   = r_writeM;
  assign address  = r_addr;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_done  = r_if_done;
  assign d_done   = r_d_done;
  assign busy     = (r_state != S_IDLE);

`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_err  = r_bus_err;
`else
  assign bus_err  = 1'b0;
`endif

endmodule
